// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage.
//   NOP              - instruction injected into IF/ID on bubbles (addi x0,x0,0)
//   DEFAULT_RESET_PC - default first fetch address after reset
//   fetch_entry_t    - {pc, instr} pair held by the response buffer
package fetch_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: 2-entry FIFO with parameterised payload width.
//   clk, rst_n     - clock, asynchronous active-low reset
//   push/wdata     - write request and payload (ignored when full unless popping)
//   pop            - remove head (ignored when empty)
//   flush          - empty the FIFO; wins over push and pop
//   rdata          - head payload (valid when !empty)
//   full/empty/count - occupancy status
module fetch_fifo2 #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          do_push_s, do_pop_s;

  // Next-state: flush clears pointers; push on full is allowed only alongside a pop.
  always_comb begin
    mem_d[0]  = mem_q[0];
    mem_d[1]  = mem_q[1];
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop && (count_q != 2'd0);
    do_push_s = push && ((count_q != 2'd2) || do_pop_s);
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage. Owns the PC, issues word-aligned
// requests to a pipelined instruction memory, buffers up to two responses and
// presents them to IF/ID, injecting a NOP when nothing is available.
//   stall_F               - hold current outputs
//   redirect_E/target_E   - taken branch/jump; flushes everything fetched/in flight
//   imem_req/imem_addr    - request, accepted every cycle req is high
//   imem_valid/imem_rdata - in-order responses, latency >= 1
//   instr_F/PC_F/PCP4_F/valid_F - IF/ID feed
// Optional feature (macro FETCH_PERF_EN): adds 32-bit wrapping counters
//   fetch_count (issued requests) and drop_count (discarded responses plus
//   flushed buffer entries).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_F,
  input  logic             redirect_E,
  input  logic [WIDTH-1:0] target_E,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_valid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_F,
  output logic [WIDTH-1:0] PC_F,
  output logic [WIDTH-1:0] PCP4_F,
  output logic             valid_F
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      fetch_count,
  output logic [31:0]      drop_count
`endif
);

  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [1:0]         drop_q, drop_d;
  logic [2*WIDTH-1:0] rsp_head_s;
  logic [WIDTH-1:0]   ifl_head_s;
  logic [1:0]         occ_s, inflight_s;
  logic               rsp_full_s, rsp_empty_s, ifl_full_s, ifl_empty_s;
  logic [2:0]         credit_s;
  logic               pop_s, issue_s, discard_s, rsp_push_s;
  logic               unused_s;

  assign pop_s    = valid_F && !stall_F;
  // Requests in flight plus buffered entries after this cycle's pop; a response
  // only moves an entry between the two terms so it does not matter here.
  assign credit_s = {1'b0, inflight_s} + {1'b0, occ_s} - {2'b00, pop_s};
  // rst_n keeps the request low while reset is held.
  assign issue_s  = rst_n && !redirect_E && !ifl_full_s && (credit_s < 3'd2);
  // A response arriving in the redirect cycle belongs to the old stream.
  assign discard_s  = imem_valid && ((drop_q != 2'd0) || redirect_E);
  assign rsp_push_s = imem_valid && (drop_q == 2'd0) && !redirect_E;
  assign unused_s   = &{1'b0, rsp_full_s, target_E[1:0]};

  fetch_fifo2 #(.DW(2*WIDTH)) u_rsp_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_push_s),
    .pop   (pop_s),
    .flush (redirect_E),
    .wdata ({ifl_head_s, imem_rdata}),
    .rdata (rsp_head_s),
    .full  (rsp_full_s),
    .empty (rsp_empty_s),
    .count (occ_s)
  );

  // In-flight PCs are never flushed: each outstanding response still has to
  // retire its PC, even when it is going to be dropped.
  fetch_fifo2 #(.DW(WIDTH)) u_ifl_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue_s),
    .pop   (imem_valid),
    .flush (1'b0),
    .wdata (pc_q),
    .rdata (ifl_head_s),
    .full  (ifl_full_s),
    .empty (ifl_empty_s),
    .count (inflight_s)
  );

  // Next PC and drop count; redirect wins over everything else.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_E) begin
      pc_d = {target_E[WIDTH-1:2], 2'b00};
      if (imem_valid && !ifl_empty_s) begin
        drop_d = inflight_s - 2'd1;
      end else begin
        drop_d = inflight_s;
      end
    end else begin
      if (issue_s) begin
        pc_d = pc_q + WIDTH'(32'd4);
      end else begin
        pc_d = pc_q;
      end
      if (imem_valid && (drop_q != 2'd0)) begin
        drop_d = drop_q - 2'd1;
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // PC and drop-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      drop_q <= 2'd0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // IF/ID feed: buffer head, or a NOP bubble when empty.
  always_comb begin
    valid_F = !rsp_empty_s;
    instr_F = WIDTH'(NOP);
    PC_F    = '0;
    if (!rsp_empty_s) begin
      instr_F = rsp_head_s[WIDTH-1:0];
      PC_F    = rsp_head_s[2*WIDTH-1:WIDTH];
    end else begin
      instr_F = WIDTH'(NOP);
      PC_F    = '0;
    end
    PCP4_F = PC_F + WIDTH'(32'd4);
  end

  assign imem_req  = issue_s;
  assign imem_addr = pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  // Counter next-state; flushed entries count as drops alongside discards.
  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, issue_s};
    drop_count_d  = drop_count_q + {31'd0, discard_s};
    if (redirect_E) begin
      drop_count_d = drop_count_d + {30'd0, occ_s};
    end else begin
      drop_count_d = drop_count_d;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= 32'd0;
      drop_count_q  <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign drop_count  = drop_count_q;
`endif

endmodule
